// File: rtl/axi_single_master.sv
// Single-outstanding AXI4 master: turns a command/response port into single-beat AXI4 writes and reads.
// Optional hung-slave watchdog is compiled in when AXI_MASTER_TIMEOUT_EN is defined.
module axi_single_master #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ADDR_WIDTH     = 16,
   parameter int unsigned STRB_WIDTH     = DATA_WIDTH / 8,
   parameter int unsigned ID_WIDTH       = 8,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ID_WIDTH-1:0]   cmd_id,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   input  logic [STRB_WIDTH-1:0] cmd_wstrb,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic                  rsp_write,
   output logic [ID_WIDTH-1:0]   rsp_id,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic [1:0]            rsp_resp,
   output logic                  rsp_id_err,
   output logic                  busy,
   output logic [ID_WIDTH-1:0]   m_axi_awid,
   output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
   output logic [7:0]            m_axi_awlen,
   output logic [2:0]            m_axi_awsize,
   output logic [1:0]            m_axi_awburst,
   output logic                  m_axi_awlock,
   output logic [3:0]            m_axi_awcache,
   output logic [2:0]            m_axi_awprot,
   output logic                  m_axi_awvalid,
   input  logic                  m_axi_awready,
   output logic [DATA_WIDTH-1:0] m_axi_wdata,
   output logic [STRB_WIDTH-1:0] m_axi_wstrb,
   output logic                  m_axi_wlast,
   output logic                  m_axi_wvalid,
   input  logic                  m_axi_wready,
   input  logic [ID_WIDTH-1:0]   m_axi_bid,
   input  logic [1:0]            m_axi_bresp,
   input  logic                  m_axi_bvalid,
   output logic                  m_axi_bready,
   output logic [ID_WIDTH-1:0]   m_axi_arid,
   output logic [ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [7:0]            m_axi_arlen,
   output logic [2:0]            m_axi_arsize,
   output logic [1:0]            m_axi_arburst,
   output logic                  m_axi_arlock,
   output logic [3:0]            m_axi_arcache,
   output logic [2:0]            m_axi_arprot,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,
   input  logic [ID_WIDTH-1:0]   m_axi_rid,
   input  logic [DATA_WIDTH-1:0] m_axi_rdata,
   input  logic [1:0]            m_axi_rresp,
   input  logic                  m_axi_rlast,
   input  logic                  m_axi_rvalid,
   output logic                  m_axi_rready
);

   localparam int unsigned LSB = $clog2(STRB_WIDTH);
   localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {ADDR_WIDTH{1'b1}} << LSB;

   typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_t;

   state_t                state_q, state_d;
   logic                  aw_done_q, aw_done_d, w_done_q, w_done_d;
   logic                  cmd_hs, b_hs, r_hs, timeout;
   logic [1:0]            rst_sync;
   logic                  rst_n;
   logic [ID_WIDTH-1:0]   id_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [STRB_WIDTH-1:0] wstrb_q;
   logic                  write_q;
   logic                  unused_ok;

   // Reset asserts asynchronously and releases on a clock edge
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) rst_sync <= '0;
      else          rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n = rst_sync[1];

   assign m_axi_awid    = id_q;
   assign m_axi_awaddr  = addr_q;
   assign m_axi_awlen   = 8'd0;
   assign m_axi_awsize  = 3'(LSB);
   assign m_axi_awburst = 2'b01;
   assign m_axi_awlock  = 1'b0;
   assign m_axi_awcache = 4'b0000;
   assign m_axi_awprot  = 3'b000;
   assign m_axi_wdata   = wdata_q;
   assign m_axi_wstrb   = wstrb_q;
   assign m_axi_wlast   = 1'b1;
   assign m_axi_arid    = id_q;
   assign m_axi_araddr  = addr_q;
   assign m_axi_arlen   = 8'd0;
   assign m_axi_arsize  = 3'(LSB);
   assign m_axi_arburst = 2'b01;
   assign m_axi_arlock  = 1'b0;
   assign m_axi_arcache = 4'b0000;
   assign m_axi_arprot  = 3'b000;

   assign cmd_hs = cmd_valid && cmd_ready;
   assign b_hs   = m_axi_bvalid && m_axi_bready;
   assign r_hs   = m_axi_rvalid && m_axi_rready;

`ifdef AXI_MASTER_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
   assign unused_ok = m_axi_rlast;
`else
   assign unused_ok = ^{m_axi_rlast, 32'(TIMEOUT_CYCLES)};
`endif

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      timeout   = 1'b0;
`ifdef AXI_MASTER_TIMEOUT_EN
      cnt_d     = '0;
`endif
      unique case (state_q)
         IDLE: begin
            if (cmd_hs) begin
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = cmd_write ? WR_REQ : RD_REQ;
            end
         end
         WR_REQ: begin
            if (m_axi_awvalid && m_axi_awready) aw_done_d = 1'b1;
            if (m_axi_wvalid && m_axi_wready)   w_done_d  = 1'b1;
            if (aw_done_d && w_done_d)          state_d   = WR_RESP;
         end
         WR_RESP: if (b_hs) state_d = RSP;
         RD_REQ:  if (m_axi_arvalid && m_axi_arready) state_d = RD_DATA;
         RD_DATA: if (r_hs) state_d = RSP;
         RSP:     if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
`ifdef AXI_MASTER_TIMEOUT_EN
      // A real handshake in the same cycle wins over the watchdog
      if (state_d == state_q && state_q inside {WR_REQ, WR_RESP, RD_REQ, RD_DATA}) begin
         cnt_d = CNT_W'(cnt_q + 1'b1);
         if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
            cnt_d   = '0;
            state_d = RSP;
            timeout = 1'b1;
         end
      end
`endif
   end

   // Outputs are registered decodes of the next state
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         aw_done_q     <= 1'b0;
         w_done_q      <= 1'b0;
         cmd_ready     <= 1'b1;
         busy          <= 1'b0;
         m_axi_awvalid <= 1'b0;
         m_axi_wvalid  <= 1'b0;
         m_axi_bready  <= 1'b0;
         m_axi_arvalid <= 1'b0;
         m_axi_rready  <= 1'b0;
         rsp_valid     <= 1'b0;
         rsp_write     <= 1'b0;
         rsp_id        <= '0;
         rsp_rdata     <= '0;
         rsp_resp      <= 2'b00;
         rsp_id_err    <= 1'b0;
         id_q          <= '0;
         addr_q        <= '0;
         wdata_q       <= '0;
         wstrb_q       <= '0;
         write_q       <= 1'b0;
      end else begin
         aw_done_q     <= aw_done_d;
         w_done_q      <= w_done_d;
         cmd_ready     <= (state_d == IDLE);
         busy          <= (state_d != IDLE);
         m_axi_awvalid <= (state_d == WR_REQ) && !aw_done_d;
         m_axi_wvalid  <= (state_d == WR_REQ) && !w_done_d;
         m_axi_bready  <= (state_d == WR_RESP);
         m_axi_arvalid <= (state_d == RD_REQ);
         m_axi_rready  <= (state_d == RD_DATA);
         rsp_valid     <= (state_d == RSP);
         if (cmd_hs) begin
            id_q    <= cmd_id;
            addr_q  <= cmd_addr & ADDR_MASK;
            wdata_q <= cmd_wdata;
            wstrb_q <= cmd_wstrb;
            write_q <= cmd_write;
         end
         if (b_hs) begin
            rsp_write  <= 1'b1;
            rsp_id     <= id_q;
            rsp_rdata  <= '0;
            rsp_resp   <= m_axi_bresp;
            rsp_id_err <= (m_axi_bid != id_q);
         end else if (r_hs) begin
            rsp_write  <= 1'b0;
            rsp_id     <= id_q;
            rsp_rdata  <= m_axi_rdata;
            rsp_resp   <= m_axi_rresp;
            rsp_id_err <= (m_axi_rid != id_q);
         end else if (timeout) begin
            rsp_write  <= write_q;
            rsp_id     <= id_q;
            rsp_rdata  <= '0;
            rsp_resp   <= 2'b10;
            rsp_id_err <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_axi_single_master.sv
// Bench for axi_single_master: behavioural AXI slave plus a word-memory reference model.
// The watchdog scenario is included when AXI_MASTER_TIMEOUT_EN is defined.
module tb_axi_single_master;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [7:0]  cmd_id;
   logic [15:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid, rsp_ready, rsp_write, rsp_id_err, busy;
   logic [7:0]  rsp_id;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic [7:0]  m_axi_awid, m_axi_arid, m_axi_bid, m_axi_rid, m_axi_awlen, m_axi_arlen;
   logic [15:0] m_axi_awaddr, m_axi_araddr;
   logic [2:0]  m_axi_awsize, m_axi_awprot, m_axi_arsize, m_axi_arprot;
   logic [1:0]  m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
   logic [3:0]  m_axi_awcache, m_axi_arcache, m_axi_wstrb;
   logic        m_axi_awlock, m_axi_awvalid, m_axi_awready, m_axi_arlock, m_axi_arvalid, m_axi_arready;
   logic [31:0] m_axi_wdata, m_axi_rdata;
   logic        m_axi_wlast, m_axi_wvalid, m_axi_wready, m_axi_bvalid, m_axi_bready;
   logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

   axi_single_master #(.TIMEOUT_CYCLES(16)) dut (
      .clock(clock), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_id(cmd_id),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write), .rsp_id(rsp_id),
      .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_id_err(rsp_id_err), .busy(busy),
      .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
      .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
      .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
      .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
      .m_axi_bready(m_axi_bready),
      .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
      .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
      .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid),
      .m_axi_arready(m_axi_arready),
      .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
      .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
   );

   always #5 clock = ~clock;

   int n_cmp = 0, n_err = 0, cyc = 0;
   // slave configuration
   int aw_delay, w_delay, b_delay, ar_delay, r_delay;
   bit id_force; logic [7:0] id_force_val; logic [1:0] bresp_val, rresp_val;
   // slave state
   int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
   bit aw_got, w_got, b_pend, r_pend;
   logic [15:0] s_awaddr, s_araddr; logic [7:0] s_awid, s_arid, s_awlen; logic [2:0] s_awsize;
   logic [31:0] s_wdata; logic [3:0] s_wstrb;
   logic [31:0] smem [logic [15:0]];
   // reference model: word-indexed memory
   logic [31:0] ref_mem [int];
   // per-command monitors
   int awv_cnt, wv_cnt, bready_first, aw_hs_cyc, w_hs_cyc;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic slave_reset();
      m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_arready = 0; m_axi_rvalid = 0;
      m_axi_bid = 0; m_axi_bresp = 0; m_axi_rid = 0; m_axi_rdata = 0; m_axi_rresp = 0; m_axi_rlast = 1;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
   endtask

   // One clock: sample handshakes, step the edge, then update slave drives and monitors
   task automatic tick();
      bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
      logic [31:0] word;
      aw_hs = m_axi_awvalid && m_axi_awready;
      w_hs  = m_axi_wvalid && m_axi_wready;
      b_hs  = m_axi_bvalid && m_axi_bready;
      ar_hs = m_axi_arvalid && m_axi_arready;
      r_hs  = m_axi_rvalid && m_axi_rready;
      if (aw_hs) begin s_awaddr = m_axi_awaddr; s_awid = m_axi_awid; s_awlen = m_axi_awlen; s_awsize = m_axi_awsize; end
      if (w_hs)  begin s_wdata = m_axi_wdata; s_wstrb = m_axi_wstrb; end
      if (ar_hs) begin s_araddr = m_axi_araddr; s_arid = m_axi_arid; end
      @(posedge clock); #1;
      cyc++;
      if (aw_hs) begin aw_got = 1; aw_hs_cyc = cyc; end
      if (w_hs)  begin w_got = 1; w_hs_cyc = cyc; end
      if (b_hs)  begin b_pend = 0; m_axi_bvalid = 0; end
      if (aw_got && w_got) begin
         word = smem.exists(s_awaddr) ? smem[s_awaddr] : 32'h0;
         for (int b = 0; b < 4; b++) if (s_wstrb[b]) word[8*b +: 8] = s_wdata[8*b +: 8];
         smem[s_awaddr] = word;
         aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0;
      end
      if (b_pend) begin
         m_axi_bvalid = (b_cnt >= b_delay); b_cnt++;
         m_axi_bid = id_force ? id_force_val : s_awid; m_axi_bresp = bresp_val;
      end
      if (r_hs) begin r_pend = 0; m_axi_rvalid = 0; end
      if (ar_hs) begin
         r_pend = 1; r_cnt = 0;
         m_axi_rdata = smem.exists(s_araddr) ? smem[s_araddr] : 32'h0;
         m_axi_rid = id_force ? id_force_val : s_arid; m_axi_rresp = rresp_val;
      end
      if (r_pend) begin m_axi_rvalid = (r_cnt >= r_delay); r_cnt++; end
      if (m_axi_awvalid) begin m_axi_awready = (aw_cnt >= aw_delay); aw_cnt++; end
      else begin m_axi_awready = 0; aw_cnt = 0; end
      if (m_axi_wvalid) begin m_axi_wready = (w_cnt >= w_delay); w_cnt++; end
      else begin m_axi_wready = 0; w_cnt = 0; end
      if (m_axi_arvalid) begin m_axi_arready = (ar_cnt >= ar_delay); ar_cnt++; end
      else begin m_axi_arready = 0; ar_cnt = 0; end
      if (m_axi_awvalid) awv_cnt++;
      if (m_axi_wvalid) wv_cnt++;
      if (m_axi_bready && bready_first < 0) bready_first = cyc;
   endtask

   task automatic set_delays(input int aw, input int w, input int b, input int ar, input int r);
      aw_delay = aw; w_delay = w; b_delay = b; ar_delay = ar; r_delay = r;
   endtask

   // Issue one command, predict its response from the model and check it
   task automatic run_cmd(input bit wr, input logic [7:0] id, input logic [15:0] addr,
                          input logic [31:0] wd, input logic [3:0] ws, input int hold);
      logic [31:0] exp_rdata, old, mask;
      logic [1:0]  exp_resp;
      logic        exp_err;
      int          widx, lat;
      bit          seen, zero_wait;
      widx = int'(addr) / 4;
      zero_wait = (aw_delay + w_delay + b_delay + ar_delay + r_delay) == 0;
      if (wr) begin
         old  = ref_mem.exists(widx) ? ref_mem[widx] : 32'h0;
         mask = 32'h0;
         for (int b = 0; b < 4; b++) if (ws[b]) mask = mask | (32'hFF << (8 * b));
         ref_mem[widx] = (old & ~mask) | (wd & mask);
         exp_rdata = 32'h0; exp_resp = bresp_val;
      end else begin
         exp_rdata = ref_mem.exists(widx) ? ref_mem[widx] : 32'h0; exp_resp = rresp_val;
      end
      exp_err = id_force && (id_force_val != id);
      cmd_write = wr; cmd_id = id; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws; cmd_valid = 1;
      seen = 0;
      for (int i = 0; i < 64 && !seen; i++) if (cmd_ready) seen = 1; else tick();
      chk("cmd_accept", 64'(seen), 64'd1);
      awv_cnt = 0; wv_cnt = 0; bready_first = -1; aw_hs_cyc = -1; w_hs_cyc = -1;
      tick();
      cmd_valid = 0;
      lat = 1; seen = 0;
      for (int i = 0; i < 200 && !seen; i++) if (rsp_valid) seen = 1; else begin tick(); lat++; end
      chk("rsp_seen", 64'(seen), 64'd1);
      if (zero_wait) chk("rsp_latency", 64'(lat), 64'd3);
      if (wr) begin
         chk("awaddr", 64'(s_awaddr), 64'(int'(addr) - int'(addr) % 4));
         chk("awid", 64'(s_awid), 64'(id));
         chk("awlen_size", 64'({s_awlen, s_awsize}), 64'({8'd0, 3'd2}));
      end else begin
         chk("araddr", 64'(s_araddr), 64'(int'(addr) - int'(addr) % 4));
      end
      for (int i = 0; i < hold; i++) begin
         chk("hold_valid", 64'(rsp_valid), 64'd1);
         chk("hold_cmd_ready", 64'(cmd_ready), 64'd0);
         chk("hold_fields", {rsp_rdata, rsp_id, rsp_resp, rsp_id_err, rsp_write},
             {exp_rdata, id, exp_resp, exp_err, wr});
         tick();
      end
      rsp_ready = 1;
      chk("rsp_write", 64'(rsp_write), 64'(wr));
      chk("rsp_id", 64'(rsp_id), 64'(id));
      chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
      chk("rsp_resp", 64'(rsp_resp), 64'(exp_resp));
      chk("rsp_id_err", 64'(rsp_id_err), 64'(exp_err));
      tick();
      rsp_ready = 0;
      chk("rsp_drop", 64'(rsp_valid), 64'd0);
      chk("cmd_ready_next", 64'(cmd_ready), 64'd1);
   endtask

   initial begin
      bit seen;
      int lat;
      reset_n = 0; cmd_valid = 0; cmd_write = 0; cmd_id = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
      rsp_ready = 0; id_force = 0; id_force_val = 0; bresp_val = 0; rresp_val = 0;
      set_delays(0, 0, 0, 0, 0);
      slave_reset();
      repeat (3) @(posedge clock);
      #1;
      chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_valids", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, rsp_valid}), 64'd0);
      chk("rst_addr_data", 64'({m_axi_awaddr, m_axi_wdata}), 64'd0);
      reset_n = 1;
      repeat (4) tick();

      // zero-wait write then read-back
      run_cmd(1, 8'd3, 16'h1236, 32'hDEADBEEF, 4'hF, 0);
      run_cmd(0, 8'd4, 16'h1234, 32'h0, 4'h0, 0);

      // slow AW, immediate W
      set_delays(5, 0, 0, 0, 0);
      run_cmd(1, 8'd5, 16'h2000, 32'h12345678, 4'h5, 0);
      chk("awvalid_cycles", 64'(awv_cnt), 64'd6);
      chk("wvalid_cycles", 64'(wv_cnt), 64'd1);
      chk("bready_after_hs", 64'(bready_first), 64'((aw_hs_cyc > w_hs_cyc) ? aw_hs_cyc : w_hs_cyc));
      set_delays(0, 0, 0, 0, 0);

      // wrong returned ID, then SLVERR pass-through
      id_force = 1; id_force_val = 8'd7;
      run_cmd(1, 8'd2, 16'h0010, 32'hA5A5A5A5, 4'hF, 0);
      id_force = 0; bresp_val = 2'b10;
      run_cmd(1, 8'd6, 16'h0014, 32'h0BADF00D, 4'hF, 0);
      bresp_val = 2'b00;

      // response back-pressure
      run_cmd(0, 8'd8, 16'h2000, 32'h0, 4'h0, 4);

      // reset while waiting for read data
      set_delays(0, 0, 0, 0, 10);
      cmd_write = 0; cmd_id = 8'd9; cmd_addr = 16'h0010; cmd_valid = 1;
      tick();
      cmd_valid = 0;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) if (m_axi_rready) seen = 1; else tick();
      chk("reach_rd_data", 64'(seen), 64'd1);
      reset_n = 0; #1;
      chk("midrst_rready", 64'(m_axi_rready), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
      slave_reset();
      #2 reset_n = 1;
      repeat (4) tick();
      chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
      set_delays(0, 0, 0, 0, 0);
      run_cmd(0, 8'd10, 16'h0010, 32'h0, 4'h0, 0);

      // randomized traffic over a small address window
      for (int k = 0; k < 24; k++) begin
         set_delays($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3));
         if (k % 3 == 0) set_delays(0, 0, 0, 0, 0);
         id_force = ($urandom_range(0, 3) == 0); id_force_val = 8'($urandom);
         bresp_val = 2'($urandom); rresp_val = 2'($urandom);
         run_cmd(1'($urandom), 8'($urandom), 16'h0100 + 16'($urandom_range(0, 15)),
                 $urandom, 4'($urandom), $urandom_range(0, 2));
      end
      id_force = 0; bresp_val = 0; rresp_val = 0;
      set_delays(0, 0, 0, 0, 0);

`ifdef AXI_MASTER_TIMEOUT_EN
      // hung read address channel
      ar_delay = 100000;
      cmd_write = 0; cmd_id = 8'd11; cmd_addr = 16'h0040; cmd_valid = 1;
      tick();
      cmd_valid = 0;
      lat = 1; seen = 0;
      for (int i = 0; i < 60 && !seen; i++) if (rsp_valid) seen = 1; else begin tick(); lat++; end
      chk("to_seen", 64'(seen), 64'd1);
      chk("to_latency", 64'(lat), 64'd17);
      chk("to_resp", 64'(rsp_resp), 64'd2);
      chk("to_arvalid", 64'(m_axi_arvalid), 64'd0);
      rsp_ready = 1; tick(); rsp_ready = 0;
      ar_delay = 0;
`else
      lat = 0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/axi_single_master.md
# axi_single_master

Single-outstanding AXI4 master that converts a simple command/response interface into single-beat (len 0) AXI4 write and read transactions. It is the initiator counterpart of the AXI PIM slave `axi_top_32x32`. It sits between a host-side sequencer, such as a Renode bridge or on-chip controller, and the slave's `s_axi_*` port, and replaces ad-hoc bench-driven AXI stimulus with synthesizable RTL.

## Interface
- `DATA_WIDTH`, 32: AXI data width.
- `ADDR_WIDTH`, 16: AXI address width.
- `STRB_WIDTH`, DATA_WIDTH/8: write-strobe width.
- `ID_WIDTH`, 8: AXI ID width.
- `TIMEOUT_CYCLES`, 256: watchdog limit. Used only with `AXI_MASTER_TIMEOUT_EN`.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `cmd_valid`  in  1 / `cmd_ready`  out  1: command handshake.
- `cmd_write`  in  1: 1 = write, 0 = read.
- `cmd_id`  in  ID_WIDTH / `cmd_addr`  in  ADDR_WIDTH / `cmd_wdata`  in  DATA_WIDTH / `cmd_wstrb`  in  STRB_WIDTH.
- `rsp_valid`  out  1 / `rsp_ready`  in  1: response handshake.
- `rsp_write`  out  1 / `rsp_id`  out  ID_WIDTH / `rsp_rdata`  out  DATA_WIDTH / `rsp_resp`  out  2 / `rsp_id_err`  out  1.
- `busy`  out  1: state is not IDLE.
- `m_axi_aw{id,addr,len,size,burst,lock,cache,prot,valid}`  out, with `m_axi_awready`  in: AXI4 write-address channel.
- `m_axi_w{data,strb,last,valid}`  out, with `m_axi_wready`  in: AXI4 write-data channel.
- `m_axi_b{id,resp,valid}`  in, with `m_axi_bready`  out: AXI4 write-response channel.
- `m_axi_ar{id,addr,len,size,burst,lock,cache,prot,valid}`  out, with `m_axi_arready`  in: AXI4 read-address channel.
- `m_axi_r{id,data,resp,last,valid}`  in, with `m_axi_rready`  out: AXI4 read-data channel.

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE:
  - `cmd_ready`=1; it is 0 in every other state.
  - On handshake, latch id/addr/wdata/wstrb/write.
  - Go to WR_REQ if `cmd_write`=1, otherwise RD_REQ.
- Address is latched with the low log2(STRB_WIDTH) bits cleared.
- Constant AXI fields: len=0, size=log2(STRB_WIDTH) (3'b010 at 32 bit), burst=2'b01, lock=0, cache=4'b0000, prot=3'b000, wlast=1.
- WR_REQ:
  - `awvalid` and `wvalid` are asserted together.
  - Each channel drops its valid on the cycle after its own handshake and is tracked by a done flag.
  - Order between the AW and W handshakes is free; same-cycle handshakes are allowed.
  - When both flags are set, go to WR_RESP.
- WR_RESP: `bready`=1. On `bvalid`, capture `bresp` and `bid`, then go to RSP.
- RD_REQ: `arvalid`=1. On `arready`, go to RD_DATA.
- RD_DATA:
  - `rready`=1. On `rvalid`, capture `rdata`, `rresp` and `rid`, then go to RSP.
  - `rlast` is not checked.
- `rsp_id_err`=1 when the captured bid/rid differs from the latched id.
- RSP:
  - `rsp_valid`=1 with all rsp fields stable.
  - On `rsp_ready`, return to IDLE.
  - For writes, `rsp_rdata`=0.
- Valid signals are never withdrawn before their handshake (AXI rule). Payload is stable while valid is high.

## Timing
- Reset (async assert, sync deassert internally):
  - State returns to IDLE.
  - All `*valid`, `bready`, `rready`, `rsp_*` and `busy` outputs go to 0.
  - AXI address/data outputs go to 0.
  - `cmd_ready` is 1 after reset.
- Reset mid-transaction aborts immediately with no response. The slave side is expected to be reset together with this block.
- All outputs are registered.
- Cycle N is the cmd handshake; AW/W or AR valid rises in N+1.
- With a zero-wait slave (ready at N+1, b/rvalid at N+2), `rsp_valid` rises at N+3.
- `bready`/`rready` are high only in WR_RESP/RD_DATA. A bvalid or rvalid presented earlier is held off.
- `rsp_ready` low holds RSP indefinitely; no new command is accepted.
- Back-to-back: the next `cmd_ready` rises the cycle after the rsp handshake.

## Configuration
- `AXI_MASTER_TIMEOUT_EN` defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) runs in WR_REQ, WR_RESP, RD_REQ and RD_DATA, and clears on every state change.
  - On reaching TIMEOUT_CYCLES, go to RSP with `rsp_resp`=2'b10 (SLVERR).
  - All pending valid signals are dropped in that same cycle. This deliberately violates AXI and is used only for hung-slave recovery.
- Not defined: no counter exists; the block waits forever.

## Test plan
- Write cmd addr 0x1236, data 0xDEADBEEF, strb 0xF, id 3, against a zero-wait slave:
  - awaddr=0x1234, awsize=3'b010 and awlen=0.
  - `rsp_valid` at N+3 with resp=00, id=3 and id_err=0.
- Read cmd addr 0x1234, id 4 after the above write → `rsp_rdata`=0xDEADBEEF, `rsp_write`=0, rsp at N+3.
- awready delayed 5 cycles, wready immediate:
  - `wvalid` is high for 1 cycle only; `awvalid` is held 6 cycles.
  - `bready` rises after both handshakes.
- Slave returns bid=7 for cmd id 2 → `rsp_id_err`=1. Separately, bresp=2'b10 is passed through as `rsp_resp`=2'b10.
- `rsp_ready` held low for 4 cycles → `rsp_valid` and fields stable throughout, `cmd_ready`=0. `cmd_ready`=1 the cycle after the rsp handshake.
- `reset_n` pulsed low during RD_DATA → `rready`, `busy` and `rsp_valid` go to 0 immediately and `cmd_ready`=1 after release.
- With `AXI_MASTER_TIMEOUT_EN` and TIMEOUT_CYCLES=16, arready tied low → rsp resp=2'b10 after 16 cycles in RD_REQ, and `arvalid` goes low.
